// File: rtl/score_keeper.sv
// Game-progress tracker: saturating score, session high score, lives and START/PLAY/WIN/LOSE state.
// Optional combo scoring is built only when SCORE_COMBO_EN is defined.
module score_keeper #(
    parameter int unsigned WIN_SCORE     = 180,
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned PTS_T0        = 10,
    parameter int unsigned PTS_T1        = 20,
    parameter int unsigned PTS_T2        = 30,
    parameter int unsigned PTS_UFO       = 50,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned HOLD_FRAMES   = 120
`ifdef SCORE_COMBO_EN
    ,
    parameter int unsigned COMBO_FRAMES  = 30
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       hit_valid,
    input  logic [1:0] hit_type,
    input  logic       player_hit,
    input  logic       aliens_landed,
    output logic [1:0] game_state,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic [1:0] lives,
    output logic       score_pulse
);

    localparam int unsigned INV_W  = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
`ifdef SCORE_COMBO_EN
    localparam int unsigned COMBO_W = (COMBO_FRAMES > 0) ? $clog2(COMBO_FRAMES + 1) : 1;
`endif

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_WIN   = 2'b10,
        ST_LOSE  = 2'b11
    } state_t;

    state_t             state;
    logic               start_q;
    logic [INV_W-1:0]   invuln;
    logic [HOLD_W-1:0]  hold;
`ifdef SCORE_COMBO_EN
    logic [COMBO_W-1:0] combo;
`endif

    logic       start_rise;
    logic [7:0] base_pts;
    logic [8:0] hit_pts;
    logic [9:0] sum;
    logic [7:0] new_score;
    logic [7:0] hi_next;
    logic       life_lost;
    logic       lose;
    logic       win;

    assign game_state = state;

    // Score arithmetic and PLAY exit decisions for the current cycle
    always_comb begin
        start_rise = start_btn & ~start_q;
        case (hit_type)
            2'd0:    base_pts = 8'(PTS_T0);
            2'd1:    base_pts = 8'(PTS_T1);
            2'd2:    base_pts = 8'(PTS_T2);
            default: base_pts = 8'(PTS_UFO);
        endcase
        hit_pts = {1'b0, base_pts};
`ifdef SCORE_COMBO_EN
        if (combo != '0) begin
            hit_pts = {base_pts, 1'b0};
        end
`endif
        sum       = 10'(score) + 10'(hit_pts);
        new_score = score;
        if (hit_valid) begin
            new_score = (sum > 10'd255) ? 8'hFF : sum[7:0];
        end
        life_lost = player_hit && (invuln == '0);
        lose      = aliens_landed || (life_lost && (lives == 2'd1));
        win       = !lose && (32'(new_score) >= WIN_SCORE);
        hi_next   = (new_score > high_score) ? new_score : high_score;
    end

    // Game-state machine with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_START;
            score       <= '0;
            high_score  <= '0;
            lives       <= '0;
            score_pulse <= 1'b0;
            start_q     <= 1'b1;
            invuln      <= '0;
            hold        <= '0;
`ifdef SCORE_COMBO_EN
            combo       <= '0;
`endif
        end else begin
            start_q     <= start_btn;
            score_pulse <= 1'b0;
            case (state)
                ST_START: begin
                    if (start_rise) begin
                        state       <= ST_PLAY;
                        score       <= '0;
                        score_pulse <= (score != '0);
                        lives       <= 2'(LIVES_INIT);
                        invuln      <= '0;
`ifdef SCORE_COMBO_EN
                        combo       <= '0;
`endif
                    end
                end
                ST_PLAY: begin
                    score       <= new_score;
                    score_pulse <= (new_score != score);
                    if (life_lost) begin
                        lives  <= lives - 2'd1;
                        invuln <= INV_W'(INVULN_FRAMES);
                    end else if (frame_tick && (invuln != '0)) begin
                        invuln <= invuln - INV_W'(1);
                    end
`ifdef SCORE_COMBO_EN
                    if (life_lost) begin
                        combo <= '0;
                    end else if (hit_valid) begin
                        combo <= COMBO_W'(COMBO_FRAMES);
                    end else if (frame_tick && (combo != '0)) begin
                        combo <= combo - COMBO_W'(1);
                    end
`endif
                    // LOSE outranks WIN; the hit's points are kept either way
                    if (lose || win) begin
                        state      <= lose ? ST_LOSE : ST_WIN;
                        high_score <= hi_next;
                        hold       <= HOLD_W'(HOLD_FRAMES);
                        if (lose) begin
                            lives <= '0;
                        end
                    end
                end
                default: begin
                    if (frame_tick && (hold != '0)) begin
                        hold <= hold - HOLD_W'(1);
                    end
                    if (start_rise && (hold == '0)) begin
                        state <= ST_START;
                    end
                end
            endcase
        end
    end

endmodule
